// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side end of the cache miss path. Accepts one single-word read or
//   write at a time, models a DEPTH-word backing RAM with a fixed access
//   latency, and answers with a one-cycle ready pulse plus {error, data}.
//
// Ports
//   iCLK               clock, rising edge
//   iRST               asynchronous active-high reset (array contents kept)
//   mem_addr           byte address of the request
//   mem_wdata          write data
//   cache2mem_MemRead  read request
//   cache2mem_MemWrite write request
//   mem2cache_data     {error, data} response, held until the next response
//   mem2cache_ready    one-cycle response-valid pulse
//   busy               request in flight; new requests are ignored
//
// Timing: a request sampled at edge 0 enters RESPOND at edge LATENCY-1. At
// that edge the array is read or written. The registered ready pulse and
// response word appear at edge LATENCY. The responder is back in IDLE for
// that ready cycle, so a request held through it is taken at edge
// LATENCY+1, one request per LATENCY+1 cycles.
module mem_responder #(
  parameter int    ADDR_W    = 32,
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              cache2mem_MemRead,
  input  logic              cache2mem_MemWrite,
  output logic [DATA_W:0]   mem2cache_data,
  output logic              mem2cache_ready,
  output logic              busy
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [DATA_W:0]   resp_q, resp_d;
  logic [DATA_W:0]   data_q, data_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem [DEPTH];

  // Decode of the live request pins. The error flag is resolved at accept
  // time so only the word index needs to be kept from the address.
  logic              reqValid;
  logic              reqErr;
  logic [IDX_W-1:0]  reqIdx;
  logic [ADDR_W-1:0] addrHigh;

  assign reqValid = cache2mem_MemRead | cache2mem_MemWrite;
  assign addrHigh = mem_addr >> (IDX_W + 2);
  assign reqErr   = (mem_addr[1:0] != 2'b00) || (addrHigh != '0) ||
                    (cache2mem_MemRead && cache2mem_MemWrite);
  assign reqIdx   = mem_addr[IDX_W+1:2];

  // With LATENCY==1 the access happens on the accept edge itself, before
  // the request is latched, so the access operands come straight from the
  // pins while in IDLE and from the latched copy otherwise.
  logic              fromIdle;
  logic [IDX_W-1:0]  curIdx;
  logic [DATA_W-1:0] curWdata;
  logic              curWrite;
  logic              curErr;

  assign fromIdle = (state_q == IDLE);
  assign curIdx   = fromIdle ? reqIdx             : idx_q;
  assign curWdata = fromIdle ? mem_wdata          : wdata_q;
  assign curWrite = fromIdle ? cache2mem_MemWrite : write_q;
  assign curErr   = fromIdle ? reqErr             : err_q;

  logic doAccess;
  logic memWe;

  // Next-state logic: accept in IDLE, count down in WAIT, spend one cycle
  // in RESPOND during which the request pins are not looked at.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    err_d    = err_q;
    doAccess = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          idx_d   = reqIdx;
          wdata_d = mem_wdata;
          write_d = cache2mem_MemWrite;
          err_d   = reqErr;
          if (LATENCY == 1) begin
            state_d  = RESPOND;
            doAccess = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(CNT_INIT);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = RESPOND;
          doAccess = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Array access on the edge entering RESPOND. Errored requests never
  // touch the array and answer with a zero data field.
  always_comb begin
    resp_d = resp_q;
    memWe  = 1'b0;
    if (doAccess) begin
      if (curErr) begin
        resp_d = {1'b1, {DATA_W{1'b0}}};
      end else if (curWrite) begin
        memWe  = 1'b1;
        resp_d = {1'b0, curWdata};
      end else begin
        resp_d = {1'b0, mem[curIdx]};
      end
    end
  end

  // Registered outputs. Ready and the response word follow the RESPOND
  // state by one edge; busy covers accept through the ready cycle.
  always_comb begin
    ready_d = (state_q == RESPOND);
    data_d  = (state_q == RESPOND) ? resp_q : data_q;
    busy_d  = (state_q != IDLE) || reqValid;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      resp_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // The array has no reset; holding off the write while iRST is high keeps
  // an aborted request from landing.
  always_ff @(posedge iCLK) begin
    if (memWe && !iRST) mem[curIdx] <= curWdata;
  end

  assign mem2cache_data  = data_q;
  assign mem2cache_ready = ready_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Drives two responders (LATENCY=4 and LATENCY=1) and compares every
//   cycle of each transaction against a word-array model of the RAM and an
//   arithmetic model of accept/ready timing.
module tb_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic [31:0] addrS  [2];
  logic [31:0] wdataS [2];
  logic        rdS    [2];
  logic        wrS    [2];
  logic [32:0] dataS  [2];
  logic        readyS [2];
  logic        busyS  [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] refMem   [2][DEPTH];
  bit          known    [2][DEPTH];
  logic [32:0] lastData [2];
  int          pool     [8] = '{5, 17, 63, 200, 511, 777, 1000, 1023};

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(4)) dutA (
    .iCLK(clk), .iRST(rst),
    .mem_addr(addrS[0]), .mem_wdata(wdataS[0]),
    .cache2mem_MemRead(rdS[0]), .cache2mem_MemWrite(wrS[0]),
    .mem2cache_data(dataS[0]), .mem2cache_ready(readyS[0]), .busy(busyS[0])
  );

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(1)) dutB (
    .iCLK(clk), .iRST(rst),
    .mem_addr(addrS[1]), .mem_wdata(wdataS[1]),
    .cache2mem_MemRead(rdS[1]), .cache2mem_MemWrite(wrS[1]),
    .mem2cache_data(dataS[1]), .mem2cache_ready(readyS[1]), .busy(busyS[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int latOf(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Model of one request: error rules, then a plain word-array update/read.
  function automatic logic [32:0] expectResp(input int i, input logic [31:0] a,
                                             input logic [31:0] d,
                                             input logic r, input logic w);
    int idx;
    if (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH) || (r && w)) return {1'b1, 32'h0};
    idx = int'(a >> 2);
    if (w) begin
      refMem[i][idx] = d;
      known[i][idx]  = 1'b1;
      return {1'b0, d};
    end
    return {1'b0, refMem[i][idx]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [31:0] a, input logic [31:0] d,
                               input logic r, input logic w);
    addrS[i]  = a;
    wdataS[i] = d;
    rdS[i]    = r;
    wrS[i]    = w;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One request pulsed for a single cycle; every cycle up to and after the
  // ready pulse is checked.
  task automatic doTxn(input int i, input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic w, input string tag);
    int lat;
    logic [32:0] exp;
    lat = latOf(i);
    exp = expectResp(i, a, d, r, w);
    applyStimulus(i, a, d, r, w);
    tick();
    applyStimulus(i, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k <= lat; k++) begin
      checkOutput({tag, ".busy"}, 64'(busyS[i]), 64'(1'b1));
      checkOutput({tag, ".ready"}, 64'(readyS[i]), 64'(k == lat));
      if (k == lat) begin
        checkOutput({tag, ".data"}, 64'(dataS[i]), 64'(exp));
        lastData[i] = exp;
      end
      tick();
    end
    checkOutput({tag, ".readyLow"}, 64'(readyS[i]), 64'(1'b0));
    checkOutput({tag, ".busyLow"}, 64'(busyS[i]), 64'(1'b0));
    checkOutput({tag, ".hold"}, 64'(dataS[i]), 64'(lastData[i]));
  endtask

  // MemRead toggled for nToggle cycles, then held for nHeld, then dropped.
  // A read is taken on any edge at least LATENCY+1 edges after the last one.
  task automatic runStream(input int i, input int nToggle, input int nHeld,
                           input logic [31:0] a, input string tag);
    int lat, lastAcc, nextFree, expCnt, gotCnt, n;
    logic r;
    logic [32:0] exp;
    lat      = latOf(i);
    lastAcc  = -1000;
    nextFree = 0;
    expCnt   = 0;
    gotCnt   = 0;
    exp      = expectResp(i, a, 32'h0, 1'b1, 1'b0);
    for (n = 0; n < nToggle + nHeld + lat + 2; n++) begin
      r = (n < nToggle) ? ((n % 2) == 1) : (n < nToggle + nHeld);
      applyStimulus(i, a, 32'h0, r, 1'b0);
      tick();
      if (r && n >= nextFree) begin
        lastAcc  = n;
        nextFree = n + lat + 1;
        expCnt++;
      end
      checkOutput({tag, ".ready"}, 64'(readyS[i]), 64'(n == lastAcc + lat));
      checkOutput({tag, ".busy"}, 64'(busyS[i]), 64'(n >= lastAcc && n <= lastAcc + lat));
      if (readyS[i] === 1'b1) gotCnt++;
      if (n == lastAcc + lat) checkOutput({tag, ".data"}, 64'(dataS[i]), 64'(exp));
    end
    applyStimulus(i, 32'h0, 32'h0, 1'b0, 1'b0);
    lastData[i] = exp;
    checkOutput({tag, ".count"}, 64'(gotCnt), 64'(expCnt));
  endtask

  // Directed sequence followed by a randomized mix on both latencies.
  initial begin
    logic [31:0] ra, rd32;
    logic rr, rw;
    int sel, kind, ii;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(i, 32'h0, 32'h0, 1'b0, 1'b0);
      lastData[i] = 33'h0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset.ready", 64'(readyS[i]), 64'(1'b0));
      checkOutput("reset.busy", 64'(busyS[i]), 64'(1'b0));
      checkOutput("reset.data", 64'(dataS[i]), 64'(33'h0));
    end
    rst = 1'b0;
    tick();

    // Read latency on the LATENCY=4 part.
    doTxn(0, 32'h0000000C, 32'h12345678, 1'b0, 1'b1, "lat_w0c");
    doTxn(0, 32'h0000000C, 32'h0, 1'b1, 1'b0, "lat_r0c");

    // Write then read back.
    doTxn(0, 32'h00000040, 32'hCAFEF00D, 1'b0, 1'b1, "wr_40");
    doTxn(0, 32'h00000040, 32'h0, 1'b1, 1'b0, "rd_40");

    // Error cases; word 0 is seeded so an aliased out-of-range write shows.
    doTxn(0, 32'h00000000, 32'h11111111, 1'b0, 1'b1, "seed_0");
    doTxn(0, 32'h00000002, 32'h0, 1'b1, 1'b0, "err_misalign");
    doTxn(0, 32'h00001000, 32'h22222222, 1'b0, 1'b1, "err_range");
    doTxn(0, 32'h00000000, 32'h0, 1'b1, 1'b0, "err_range_rd0");
    doTxn(0, 32'h00000040, 32'h33333333, 1'b1, 1'b1, "err_both");
    doTxn(0, 32'h00000040, 32'h0, 1'b1, 1'b0, "err_both_rd40");

    // Requests toggled while busy, then held.
    runStream(0, 12, 12, 32'h00000040, "busy_a");

    // Asynchronous reset with a write pending in WAIT.
    doTxn(0, 32'h00000010, 32'h0BADF00D, 1'b0, 1'b1, "pre_w10");
    applyStimulus(0, 32'h00000010, 32'hDEADBEEF, 1'b0, 1'b1);
    tick();
    applyStimulus(0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("rstmid.ready", 64'(readyS[0]), 64'(1'b0));
    checkOutput("rstmid.busy", 64'(busyS[0]), 64'(1'b0));
    checkOutput("rstmid.data", 64'(dataS[0]), 64'(33'h0));
    lastData[0] = 33'h0;
    lastData[1] = 33'h0;
    #1 rst = 1'b0;
    @(negedge clk);
    doTxn(0, 32'h00000010, 32'h0, 1'b1, 1'b0, "rst_rd10");

    // LATENCY=1 part: single read, then back-to-back held reads.
    doTxn(1, 32'h0000000C, 32'h12345678, 1'b0, 1'b1, "l1_w0c");
    doTxn(1, 32'h0000000C, 32'h0, 1'b1, 1'b0, "l1_r0c");
    runStream(1, 0, 10, 32'h0000000C, "l1_stream");
    runStream(1, 7, 6, 32'h0000000C, "l1_toggle");

    // Randomized mix on both parts.
    for (int t = 0; t < 40; t++) begin
      ii   = t % 2;
      sel  = $urandom_range(0, 7);
      kind = $urandom_range(0, 9);
      ra   = 32'(pool[sel] * 4);
      rd32 = $urandom;
      rw   = 1'($urandom_range(0, 1));
      rr   = !rw;
      if (!rw && !known[ii][pool[sel]]) begin
        rw = 1'b1;
        rr = 1'b0;
      end
      case (kind)
        0: ra = ra | 32'($urandom_range(1, 3));
        1: ra = ra | (32'h1 << $urandom_range(12, 31));
        2: begin
          rr = 1'b1;
          rw = 1'b1;
        end
        default: ;
      endcase
      doTxn(ii, ra, rd32, rr, rw, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
